// File: rtl/vector_pack_pkg.sv
// Shared types and helpers for the serial-to-parallel bit packer.
// Imported by the packer interface and the packer itself.
package vector_pack_pkg;

  typedef enum logic {S_IDLE, S_FILL} pack_state_t;

  // Width of a counter able to hold the values 0..width inclusive.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/vector_pack_if.sv
// Handshake bundle of the bit packer: serial input side, word output side, flush and fill level.
// The master drives bits and consumes words; the packer is the slave.
interface vector_pack_if #(
  parameter int unsigned WIDTH = 3
) ();
  import vector_pack_pkg::*;

  localparam int unsigned CW = cnt_w(WIDTH);

  logic             flush;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outv;
  logic [CW-1:0]    fill;

  modport master (
    output flush, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, outv, fill
  );

  modport slave (
    input  flush, in_valid, in_bit, out_ready,
    output in_ready, out_valid, outv, fill
  );

endinterface

// File: rtl/vector_pack.sv
// Serial-to-parallel packer: gathers WIDTH accepted bits into one word held in a
// single-entry output slot with valid/ready on both sides.
module vector_pack
  import vector_pack_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst,
  vector_pack_if.slave bus
);

  localparam int unsigned CW = cnt_w(WIDTH);

  pack_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] outv_q, outv_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             accept;
  logic             deliver;
  logic             load;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_q[WIDTH-2:0], bus.in_bit};
    end else begin : g_lsb_first
      assign shifted = {bus.in_bit, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit     = (cnt_q == CW'(WIDTH - 1));
  // The completing bit waits only while the output slot is full and not draining.
  assign bus.in_ready = !last_bit || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign deliver      = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    load    = 1'b0;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
          cnt_d   = CW'(1);
          shreg_d = shifted;
        end
        S_FILL: begin
          if (last_bit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            load    = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shreg_d = shifted;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end
      endcase
    end
  end

  // Output slot: a load on the delivering edge keeps out_valid high with the new word.
  always_comb begin
    outv_d      = outv_q;
    out_valid_d = out_valid_q;
    if (load) begin
      outv_d      = shifted;
      out_valid_d = 1'b1;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      outv_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      outv_q      <= outv_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.outv      = outv_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fill      = cnt_q;

endmodule
